// File: rtl/fruit_feeder.sv
// fruit_feeder: turns "N fruits of kind K" requests into N single-cycle
// fruit pulses (sel/apple/cherry) for the bowl accumulator, spaced by GAP
// idle cycles, while mirroring the bowl value in juice_exp.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// FEED  | issuing pulses; hold pauses issue, gap counter spaces pulses
// DONE  | one-cycle completion strobe, last pulse still visible
module fruit_feeder #(
  parameter int CNT_W      = 4,
  parameter int JUICE_W    = 3,
  parameter int JUICE_INIT = 5,
  parameter int GAP        = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CNT_W-1:0]   req_count,
  input  logic               req_apple,
  input  logic               hold,
  output logic               sel,
  output logic               apple,
  output logic               cherry,
  output logic               busy,
  output logic               done,
  output logic [JUICE_W-1:0] juice_exp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0]         GAP_L  = 3'(GAP);
  localparam logic [JUICE_W-1:0] JINIT  = JUICE_W'(JUICE_INIT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               kind_q, kind_d;
  logic [2:0]         gap_q, gap_d;
  logic               sel_q, sel_d;
  logic               apple_q, apple_d;
  logic               cherry_q, cherry_d;
  logic [JUICE_W-1:0] juice_q, juice_d;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      kind_q      <= 1'b0;
      gap_q       <= '0;
      sel_q       <= 1'b0;
      apple_q     <= 1'b0;
      cherry_q    <= 1'b0;
      juice_q     <= JINIT;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      kind_q      <= kind_d;
      gap_q       <= gap_d;
      sel_q       <= sel_d;
      apple_q     <= apple_d;
      cherry_q    <= cherry_d;
      juice_q     <= juice_d;
    end
  end

  // Next-state logic; pulse registers default to cleared so every
  // non-issuing edge (including DONE->IDLE) drops the pulse.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    kind_d      = kind_q;
    gap_d       = gap_q;
    sel_d       = 1'b0;
    apple_d     = 1'b0;
    cherry_d    = 1'b0;
    juice_d     = juice_q;
    case (state_q)
      IDLE: begin
        gap_d = '0;
        if (req_valid) begin
          remaining_d = req_count;
          kind_d      = req_apple;
          state_d     = (req_count == '0) ? DONE : FEED;
        end
      end
      FEED: begin
        if (!hold && (gap_q == '0)) begin
          sel_d       = kind_q;
          apple_d     = kind_q;
          cherry_d    = ~kind_q;
          remaining_d = remaining_q - CNT_W'(1);
          juice_d     = juice_q + JUICE_W'(1);
          gap_d       = GAP_L;
          if (remaining_q == CNT_W'(1)) state_d = DONE;
        end else if (!hold) begin
          gap_d = gap_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign sel       = sel_q;
  assign apple     = apple_q;
  assign cherry    = cherry_q;
  assign juice_exp = juice_q;

endmodule

// File: tb/tb_fruit_feeder.sv
// Bench for fruit_feeder: two instances (GAP=0 and GAP=2) share stimulus;
// a negedge monitor scoreboards every pulse against queued expectations.
module tb_fruit_feeder;

  localparam int CNT_W = 4;
  localparam int JW    = 3;
  localparam int JINIT = 5;

  typedef int iq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0;
  logic req_apple = 1'b0;
  logic hold = 1'b0;
  logic [CNT_W-1:0] req_count = '0;

  logic [1:0] rdy, sel, apl, chy, bsy, dn;
  logic [JW-1:0] jx [2];
  logic [JW-1:0] juice;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fruit_feeder #(.CNT_W(CNT_W), .JUICE_W(JW), .JUICE_INIT(JINIT), .GAP(2*g)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[g]),
      .req_count(req_count), .req_apple(req_apple), .hold(hold),
      .sel(sel[g]), .apple(apl[g]), .cherry(chy[g]), .busy(bsy[g]),
      .done(dn[g]), .juice_exp(jx[g])
    );
  end

  // Downstream bowl accumulator fed by the GAP=0 instance.
  always @(posedge clk) begin
    if (!rst) juice <= JW'(JINIT);
    else if ((sel[0] & apl[0]) | (~sel[0] & chy[0])) juice <= juice + 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state, one slot per instance.
  logic [3:0]    exp_q [2][$];
  int            pc [2][$];
  int            acc_cyc [2];
  int            done_rel [2];
  int            left [2];
  int            nreq [2];
  int            free_cnt [2];
  bit            active [2];
  bit            just_acc [2];
  bit            first [2];
  logic [JW-1:0] mjuice [2];
  logic [JW-1:0] prev_jx0;
  logic          prev_hold = 1'b0;
  logic          prev_rst = 1'b0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      mjuice[i] = JW'(JINIT); active[i] = 0; left[i] = 0; done_rel[i] = -1;
      acc_cyc[i] = 0; nreq[i] = 0; free_cnt[i] = 0; just_acc[i] = 0; first[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit pulse;
      logic [3:0] e;
      logic [JW-1:0] tj;
      pulse = sel[i] | apl[i] | chy[i];
      if (!prev_rst) begin
        chk("rst_outputs", {27'd0, sel[i], apl[i], chy[i], dn[i], bsy[i]}, 0);
        chk("rst_ready", rdy[i], 1);
        chk("rst_juice", jx[i], JINIT);
      end else begin
        if (pulse) begin
          chk("pulse_shape", (sel[i] & apl[i] & ~chy[i]) | (~sel[i] & ~apl[i] & chy[i]), 1);
          if (exp_q[i].size() == 0) begin
            chk("unexpected_pulse", 1, 0);
          end else begin
            e = exp_q[i].pop_front();
            chk("pulse_kind", sel[i], e[3]);
            chk("pulse_juice", jx[i], e[2:0]);
            chk("pulse_after_hold", prev_hold, 0);
            chk("pulse_spacing", free_cnt[i], first[i] ? 0 : 2*i);
            first[i] = 0;
            free_cnt[i] = 0;
            left[i]--;
            pc[i].push_back(cyc - acc_cyc[i]);
            mjuice[i] = mjuice[i] + 1'b1;
          end
        end else if (active[i] && !just_acc[i] && !prev_hold && left[i] > 0) begin
          free_cnt[i]++;
        end
        chk("juice_exp", jx[i], mjuice[i]);
        chk("busy", bsy[i], active[i]);
        chk("ready", rdy[i], !active[i]);
        if (dn[i]) begin
          if (!active[i]) begin
            chk("done_unexpected", 1, 0);
          end else begin
            chk("done_left", left[i], 0);
            if (nreq[i] == 0) chk("done_zero_latency", cyc - acc_cyc[i], 1);
            else chk("done_with_last_pulse", pulse, 1);
            done_rel[i] = cyc - acc_cyc[i];
          end
          active[i] = 0;
        end
        just_acc[i] = 0;
      end
      if (!rst) begin
        exp_q[i].delete();
        active[i] = 0;
        left[i] = 0;
        mjuice[i] = JW'(JINIT);
      end else if (req_valid && rdy[i]) begin
        nreq[i] = int'(req_count);
        left[i] = int'(req_count);
        active[i] = 1;
        just_acc[i] = 1;
        first[i] = 1;
        free_cnt[i] = 0;
        acc_cyc[i] = cyc;
        done_rel[i] = -1;
        pc[i].delete();
        tj = mjuice[i];
        for (int k = 0; k < int'(req_count); k++) begin
          tj = tj + 1'b1;
          exp_q[i].push_back({req_apple, tj});
        end
      end
    end
    if (prev_rst) chk("bowl_vs_juice_exp", juice, prev_jx0);
    prev_jx0 = jx[0];
    prev_hold = hold;
    prev_rst = rst;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic iq_t plan(input int n, input int gap);
    iq_t q;
    for (int k = 0; k < n; k++) q.push_back(2 + k*(gap+1));
    return q;
  endfunction

  task automatic cmp_pulses(input int i, input string name, input iq_t exp, input int exp_done);
    chk({name, "_npulses"}, pc[i].size(), exp.size());
    foreach (exp[k]) if (k < pc[i].size()) chk({name, "_pulse_cycle"}, pc[i][k], exp[k]);
    chk({name, "_done_cycle"}, done_rel[i], exp_done);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((bsy[0] | bsy[1]) && t < 300) begin tick(); t++; end
    chk({name, "_timeout"}, t < 300, 1);
  endtask

  task automatic req(input int n, input bit kind);
    int t;
    req_count = CNT_W'(n); req_apple = kind; req_valid = 1'b1;
    t = 0;
    while (!(rdy[0] & rdy[1]) && t < 300) begin tick(); t++; end
    tick();
    req_valid = 1'b0;
    wait_idle("req");
  endtask

  task automatic run_plan(input int n, input bit kind, input string name);
    req(n, kind);
    for (int i = 0; i < 2; i++)
      cmp_pulses(i, name, plan(n, 2*i), (n == 0) ? 1 : 2 + (n-1)*(2*i+1));
  endtask

  initial begin
    int first_acc;
    int t;
    iq_t q;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick();

    run_plan(3, 1'b1, "apple_burst");
    chk("apple_wrap_juice", jx[0], 0);
    run_plan(2, 1'b0, "cherry_burst");
    run_plan(0, 1'b1, "zero_count");
    run_plan(5, 1'b0, "cherry_five");

    // Hold during relative cycles 3..5.
    req_count = 4'd4; req_apple = 1'b1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(2);
    hold = 1'b1;
    tick(3);
    hold = 1'b0;
    wait_idle("hold");
    q = '{2, 3, 7, 8};
    cmp_pulses(0, "hold_gap0", q, 8);
    q = '{2, 8, 11, 14};
    cmp_pulses(1, "hold_gap2", q, 14);

    // Reset at the edge ending relative cycle 4 of an 8-fruit request.
    req_count = 4'd8; req_apple = 1'b1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_pulses_clear", {sel[0], apl[0], chy[0]}, 0);
    chk("midrst_busy", bsy[0], 0);
    chk("midrst_ready", rdy[0], 1);
    chk("midrst_juice", jx[0], JINIT);
    tick(6);
    q = '{2, 3, 4};
    cmp_pulses(0, "midrst_gap0", q, -1);
    q = '{2};
    cmp_pulses(1, "midrst_gap2", q, -1);

    // Back-to-back with valid held high.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    req_count = 4'd1; req_apple = 1'b1; req_valid = 1'b1;
    tick();
    first_acc = acc_cyc[0];
    req_count = 4'd2; req_apple = 1'b0;
    t = 0;
    while (!rdy[0] && t < 50) begin tick(); t++; end
    tick();
    req_valid = 1'b0;
    chk("b2b_accept_cycle", acc_cyc[0] - first_acc, 3);
    wait_idle("b2b");
    tick(2);
    chk("b2b_final_bowl", juice, 0);
    chk("b2b_final_juice_exp", jx[0], 0);

    // Randomized traffic with random hold and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 2) == 0);
      req_count = CNT_W'($urandom_range(0, 15));
      req_apple = $urandom_range(0, 1);
      hold = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 149) != 0);
      tick();
    end
    req_valid = 1'b0; hold = 1'b0; rst = 1'b1;
    tick();
    wait_idle("drain");
    tick(2);
    chk("drain_queue0", exp_q[0].size(), 0);
    chk("drain_queue1", exp_q[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fruit_feeder.md
Name: fruit_feeder

Overview:
- Drives the fruit-selection inputs (sel, apple, cherry) of the bowl accumulator.
- Accepts a request "N fruits of kind K" over a valid/ready handshake and emits exactly N single-cycle fruit pulses, each separated by GAP idle cycles.
- Keeps a mirror of the downstream bowl value, so a checker can compare juice against juice_exp.
- Sits between the test or control sequencer and the accumulator.

Parameters:
- CNT_W, 4, width of the request count (max N = 2^CNT_W-1).
- JUICE_W, 3, width of the mirrored bowl value.
- JUICE_INIT, 5, bowl value after reset. Must match the accumulator reset value.
- GAP, 0, idle cycles inserted between consecutive fruit pulses (0..7).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; 1 only in IDLE.
- req_count  in  CNT_W  number of fruits N.
- req_apple  in  1  kind: 1 = apple, 0 = cherry.
- hold  in  1  pauses issue while 1.
- sel  out  1  registered; 1 during an apple pulse, else 0.
- apple  out  1  registered; 1 during an apple pulse, else 0.
- cherry  out  1  registered; 1 during a cherry pulse, else 0.
- busy  out  1  state != IDLE.
- done  out  1  1 for exactly one cycle when a request completes.
- juice_exp  out  JUICE_W  predicted bowl value.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE; sel=apple=cherry=0; done=0; busy=0; juice_exp=JUICE_INIT; gap counter=0.
  - req_ready=1 from the first cycle after reset.
  - Reset mid-request discards the request with no further pulses.
- States: IDLE, FEED, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch req_count into remaining and req_apple into kind.
  - If req_count=0, go to DONE; otherwise go to FEED.
  - req_valid=0 stays in IDLE.
  - Request inputs are ignored outside IDLE.
- FEED, at each edge:
  - Issue condition: hold=0 and gap counter=0.
  - When issuing:
    - Set the pulse registers: apple kind gives sel=1, apple=1, cherry=0; cherry kind gives sel=0, apple=0, cherry=1.
    - remaining -= 1.
    - juice_exp += 1, modulo 2^JUICE_W (7 wraps to 0).
    - Gap counter = GAP.
    - If remaining reaches 0, go to DONE.
  - When not issuing: clear the pulse registers.
    - If hold=0 and gap counter>0, decrement the gap counter.
    - hold=1 freezes the gap counter and remaining.
- DONE:
  - done=1 for one cycle, then IDLE.
  - The last fruit pulse is visible in the DONE cycle.
  - Pulse registers are cleared at the DONE->IDLE edge.
- Pulse invariant: every pulse cycle has (sel&apple)|(~sel&cherry)=1; every other cycle has sel=apple=cherry=0.
- Latency: cycle 0 is the acceptance cycle (valid&ready sampled).
  - GAP=0, no hold: pulses in cycles 2..N+1, done in cycle N+1, req_ready=1 in cycle N+2.
  - N=0: done in cycle 1, req_ready in cycle 2, no pulses.
- juice_exp timing: updates on the same edge that raises a pulse, so it leads the downstream bowl register by one cycle. No reset of juice_exp occurs between requests; it accumulates across requests.
- hold asserted in IDLE or DONE has no effect.

Test Plan:
- Apple burst:
  - Stimulus: reset, then req N=3, apple=1, GAP=0.
  - Required: sel=apple=1 in cycles 2,3,4; cherry=0 throughout; done in cycle 4; juice_exp 5->6->7->0 (wrap); req_ready back in cycle 5.
- Cherry burst with gap:
  - Stimulus: req N=2, apple=0, GAP=2.
  - Required: cherry=1 in cycles 2 and 5, sel=0 throughout; done in cycle 5; juice_exp advances by 2.
- Zero count:
  - Stimulus: req N=0.
  - Required: no pulse; done in cycle 1; juice_exp unchanged; req_ready in cycle 2.
- Hold:
  - Stimulus: req N=4 apple, hold=1 during cycles 3-5.
  - Required: pulses in cycles 2,3 and 7,8 (hold blocks issue at the edges ending cycles 3,4,5); done in cycle 8; exactly 4 pulses total.
- Reset mid-operation:
  - Stimulus: req N=8 apple; rst=0 at the edge ending cycle 4.
  - Required: next cycle all pulse outputs=0, busy=0, juice_exp=5, req_ready=1; no further pulses.
- Back-to-back requests with checker:
  - Stimulus: req_valid held high with N=1 apple, then N=2 cherry; instantiate the accumulator downstream.
  - Required: second request accepted in the first IDLE cycle; downstream juice equals the previous-cycle juice_exp every cycle; final juice = 5+3 = 0 mod 8.
